// File: rtl/buffered_matrixn_colorspace_converter_if.sv
// Streaming pixel bus of the NxN grayscale window converter: RGB input
// qualifiers towards the converter, window/coordinate/status outputs back.
interface buffered_matrixn_colorspace_converter_if #(
    parameter int P_FRAME_COLUMNS  = 640,
    parameter int P_FRAME_ROWS     = 480,
    parameter int P_PIXEL_DEPTH    = 24,
    parameter int P_MATRIX_SIZE    = 3,
    parameter int P_INCLUDE_CENTER = 0
);
    localparam int SD            = P_PIXEL_DEPTH / 3;
    localparam int P_COL_BITS    = $clog2(P_FRAME_COLUMNS);
    localparam int P_ROW_BITS    = $clog2(P_FRAME_ROWS);
    localparam int P_MATRIX_BITS = SD * (P_MATRIX_SIZE * P_MATRIX_SIZE - 1 + P_INCLUDE_CENTER);

    logic [P_PIXEL_DEPTH-1:0] I_PIXEL;
    logic                     I_DATA_ENABLE;
    logic                     I_VSYNC;
    logic [P_COL_BITS-1:0]    O_PIXEL_COLUMN;
    logic [P_ROW_BITS-1:0]    O_PIXEL_ROW;
    logic [P_MATRIX_BITS-1:0] O_PIXEL_MATRIX;
    logic                     O_PIXEL_MATRIX_READY;
    logic                     O_FRAME_DONE;
    logic                     O_FRAME_ABORT;

    modport master (
        output I_PIXEL, I_DATA_ENABLE, I_VSYNC,
        input  O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_MATRIX,
        input  O_PIXEL_MATRIX_READY, O_FRAME_DONE, O_FRAME_ABORT
    );

    modport slave (
        input  I_PIXEL, I_DATA_ENABLE, I_VSYNC,
        output O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_MATRIX,
        output O_PIXEL_MATRIX_READY, O_FRAME_DONE, O_FRAME_ABORT
    );
endinterface

// File: rtl/buffered_matrixn_colorspace_converter.sv
// Grayscales a streamed RGB frame, buffers N-1 lines and emits every full NxN
// window with its top-left coordinate. Pipeline: gray (s1) -> window (s2) -> outputs.
module buffered_matrixn_colorspace_converter #(
    parameter int P_FRAME_COLUMNS  = 640,
    parameter int P_FRAME_ROWS     = 480,
    parameter int P_PIXEL_DEPTH    = 24,
    parameter int P_MATRIX_SIZE    = 3,
    parameter int P_INCLUDE_CENTER = 0
) (
    input  logic I_CLK,
    input  logic I_RESET,
    input  logic I_ENABLE,
    buffered_matrixn_colorspace_converter_if.slave bus
);
    localparam int SD            = P_PIXEL_DEPTH / 3;
    localparam int N             = P_MATRIX_SIZE;
    localparam int CIDX          = (N / 2) * N + (N / 2);
    localparam int P_COL_BITS    = $clog2(P_FRAME_COLUMNS);
    localparam int P_ROW_BITS    = $clog2(P_FRAME_ROWS);
    localparam int M_ELEMS       = N * N - 1 + P_INCLUDE_CENTER;
    localparam int P_MATRIX_BITS = SD * M_ELEMS;
    localparam logic [P_COL_BITS-1:0] LAST_COL = P_COL_BITS'(P_FRAME_COLUMNS - 1);
    localparam logic [P_ROW_BITS-1:0] LAST_ROW = P_ROW_BITS'(P_FRAME_ROWS - 1);
    localparam logic [P_COL_BITS-1:0] EDGE_COL = P_COL_BITS'(N - 1);
    localparam logic [P_ROW_BITS-1:0] EDGE_ROW = P_ROW_BITS'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Maps output slot k (row-major, MSB first) to the window element it carries.
    function automatic int src_index(input int k);
        return ((P_INCLUDE_CENTER == 0) && (k >= CIDX)) ? k + 1 : k;
    endfunction

    state_t                   state_q, state_d;
    logic [P_COL_BITS-1:0]    col_q, col_d;
    logic [P_ROW_BITS-1:0]    row_q, row_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [SD-1:0]            s1_gray_q, s1_gray_d;
    logic [P_COL_BITS-1:0]    s1_col_q, s1_col_d;
    logic [P_ROW_BITS-1:0]    s1_row_q, s1_row_d;
    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_last_q, s2_last_d;
    logic [P_COL_BITS-1:0]    s2_col_q, s2_col_d;
    logic [P_ROW_BITS-1:0]    s2_row_q, s2_row_d;
    logic [SD-1:0]            win_q [N][N];
    logic [SD-1:0]            win_d [N][N];
    logic [SD-1:0]            lb_q [N-1][P_FRAME_COLUMNS];
    logic [SD-1:0]            lb_wr_data_s [N-1];
    logic [SD-1:0]            col_vec_s [N];
    logic                     lb_wr_en_s;
    logic                     accept_s;
    logic                     abort_s;
    logic [SD-1:0]            gray_s;
    logic [P_MATRIX_BITS-1:0] mat_s;
    logic [P_COL_BITS-1:0]    out_col_q, out_col_d;
    logic [P_ROW_BITS-1:0]    out_row_q, out_row_d;
    logic [P_MATRIX_BITS-1:0] out_mat_q, out_mat_d;
    logic                     out_rdy_q, out_rdy_d;
    logic                     out_done_q, out_done_d;
    logic                     out_abort_q, out_abort_d;

    // Front end: accept/abort qualification, grayscale, position counters and FSM.
    always_comb begin
        accept_s   = I_ENABLE & bus.I_DATA_ENABLE & ~bus.I_VSYNC;
        abort_s    = I_ENABLE & bus.I_VSYNC & (state_q != ST_IDLE);
        gray_s     = SD'(({2'b00, bus.I_PIXEL[3*SD-1:2*SD]}
                        + {1'b0, bus.I_PIXEL[2*SD-1:SD], 1'b0}
                        + {2'b00, bus.I_PIXEL[SD-1:0]}) >> 2);
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        s1_valid_d = I_ENABLE ? accept_s : s1_valid_q;
        s1_gray_d  = s1_gray_q;
        s1_col_d   = s1_col_q;
        s1_row_d   = s1_row_q;
        if (abort_s) begin
            state_d    = ST_IDLE;
            col_d      = '0;
            row_d      = '0;
            s1_valid_d = 1'b0;
        end else if (accept_s) begin
            s1_gray_d = gray_s;
            s1_col_d  = col_q;
            s1_row_d  = row_q;
            case (state_q)
                ST_IDLE:   state_d = ST_FILL;
                ST_FILL:   state_d = ((row_q == EDGE_ROW) && (col_q == '0)) ? ST_STREAM : ST_FILL;
                ST_STREAM: state_d = ST_STREAM;
                default:   state_d = ST_IDLE;
            endcase
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = row_q + P_ROW_BITS'(1);
                end
            end else begin
                col_d = col_q + P_COL_BITS'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // Window stage: read the vertical column, shift line buffers and window.
    always_comb begin
        for (int i = 0; i < N - 1; i++) begin
            col_vec_s[i] = lb_q[i][s1_col_q];
        end
        col_vec_s[N-1] = s1_gray_q;
        for (int i = 0; i < N - 1; i++) begin
            lb_wr_data_s[i] = col_vec_s[i+1];
        end
        lb_wr_en_s = I_ENABLE & s1_valid_q & ~abort_s;
        win_d      = win_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_col_d   = s2_col_q;
        s2_row_d   = s2_row_q;
        if (abort_s) begin
            s2_valid_d = 1'b0;
        end else if (I_ENABLE) begin
            s2_valid_d = s1_valid_q && (s1_col_q >= EDGE_COL) && (s1_row_q >= EDGE_ROW);
            if (s1_valid_q) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N - 1; j++) begin
                        win_d[i][j] = win_q[i][j+1];
                    end
                    win_d[i][N-1] = col_vec_s[i];
                end
                s2_col_d  = s1_col_q - EDGE_COL;
                s2_row_d  = s1_row_q - EDGE_ROW;
                s2_last_d = (s1_col_q == LAST_COL) && (s1_row_q == LAST_ROW);
            end else begin
                s2_last_d = s2_last_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Output stage: pack the window and raise the qualifying pulses.
    always_comb begin
        mat_s = '0;
        for (int k = 0; k < M_ELEMS; k++) begin
            mat_s[P_MATRIX_BITS-1-k*SD -: SD] = win_q[src_index(k)/N][src_index(k)%N];
        end
        out_rdy_d   = I_ENABLE & s2_valid_q & ~abort_s;
        out_done_d  = out_rdy_d & s2_last_q;
        out_abort_d = abort_s;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_mat_d   = out_mat_q;
        if (out_rdy_d) begin
            out_col_d = s2_col_q;
            out_row_d = s2_row_q;
            out_mat_d = mat_s;
        end else begin
            out_mat_d = out_mat_q;
        end
    end

    // Control, pipeline and output registers with synchronous active-low reset.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_col_q    <= '0;
            s2_row_q    <= '0;
            win_q       <= '{default: '0};
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_mat_q   <= '0;
            out_rdy_q   <= 1'b0;
            out_done_q  <= 1'b0;
            out_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_gray_q   <= s1_gray_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_col_q    <= s2_col_d;
            s2_row_q    <= s2_row_d;
            win_q       <= win_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_mat_q   <= out_mat_d;
            out_rdy_q   <= out_rdy_d;
            out_done_q  <= out_done_d;
            out_abort_q <= out_abort_d;
        end
    end

    // Line buffer storage; contents are overwritten before use, so no reset.
    always_ff @(posedge I_CLK) begin
        if (lb_wr_en_s) begin
            for (int i = 0; i < N - 1; i++) begin
                lb_q[i][s1_col_q] <= lb_wr_data_s[i];
            end
        end
    end

    assign bus.O_PIXEL_COLUMN       = out_col_q;
    assign bus.O_PIXEL_ROW          = out_row_q;
    assign bus.O_PIXEL_MATRIX       = out_mat_q;
    assign bus.O_PIXEL_MATRIX_READY = out_rdy_q;
    assign bus.O_FRAME_DONE         = out_done_q;
    assign bus.O_FRAME_ABORT        = out_abort_q;
endmodule

// File: tb/tb_buffered_matrixn_colorspace_converter.sv
// Directed bench: an 8x6 frame driven into two converters in parallel,
// N=3 without centre (dut_a) and N=5 with centre (dut_b).
module tb_buffered_matrixn_colorspace_converter;
    logic        clk;
    logic        rst;
    logic        en;
    logic        de;
    logic        vs;
    logic [23:0] pix;

    buffered_matrixn_colorspace_converter_if #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
        .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3), .P_INCLUDE_CENTER(0)) if_a ();
    buffered_matrixn_colorspace_converter_if #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
        .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(5), .P_INCLUDE_CENTER(1)) if_b ();

    buffered_matrixn_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
        .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3), .P_INCLUDE_CENTER(0)) dut_a (
        .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .bus(if_a.slave));
    buffered_matrixn_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
        .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(5), .P_INCLUDE_CENTER(1)) dut_b (
        .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .bus(if_b.slave));

    assign if_a.I_PIXEL       = pix;
    assign if_a.I_DATA_ENABLE = de;
    assign if_a.I_VSYNC       = vs;
    assign if_b.I_PIXEL       = pix;
    assign if_b.I_DATA_ENABLE = de;
    assign if_b.I_VSYNC       = vs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc22 = 0;
    int a_cnt, a_done_cnt, a_abort_cnt, a_first_cyc, a_first_col, a_first_row, a_done_col, a_done_row;
    int b_cnt, b_done_cnt, b_abort_cnt, b_done_col, b_done_row;
    logic [255:0] a_first_mat;
    logic [255:0] b_first_mat;
    logic [255:0] b_ramp_mat;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        a_cnt = 0; a_done_cnt = 0; a_abort_cnt = 0; a_first_cyc = -1;
        a_first_col = -1; a_first_row = -1; a_done_col = -1; a_done_row = -1;
        b_cnt = 0; b_done_cnt = 0; b_abort_cnt = 0; b_done_col = -1; b_done_row = -1;
        a_first_mat = '1; b_first_mat = '1;
    endtask

    // One clock: outputs are sampled 1 time unit after the edge and tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (if_a.O_PIXEL_MATRIX_READY) begin
            a_cnt++;
            if (a_cnt == 1) begin
                a_first_mat = 256'(if_a.O_PIXEL_MATRIX);
                a_first_col = int'(if_a.O_PIXEL_COLUMN);
                a_first_row = int'(if_a.O_PIXEL_ROW);
                a_first_cyc = cyc;
            end
        end
        if (if_a.O_FRAME_DONE) begin
            a_done_cnt++;
            a_done_col = int'(if_a.O_PIXEL_COLUMN);
            a_done_row = int'(if_a.O_PIXEL_ROW);
        end
        if (if_a.O_FRAME_ABORT) a_abort_cnt++;
        if (if_b.O_PIXEL_MATRIX_READY) begin
            b_cnt++;
            if (b_cnt == 1) b_first_mat = 256'(if_b.O_PIXEL_MATRIX);
        end
        if (if_b.O_FRAME_DONE) begin
            b_done_cnt++;
            b_done_col = int'(if_b.O_PIXEL_COLUMN);
            b_done_row = int'(if_b.O_PIXEL_ROW);
        end
        if (if_b.O_FRAME_ABORT) b_abort_cnt++;
    endtask

    // Drives one frame; abort_at<0 means no abort, stall inserts 5 disabled cycles after (2,2).
    task automatic send_frame(input bit ramp, input logic [23:0] cpix, input int abort_at, input bit stall);
        clear_counts();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r * 8 + c == abort_at) begin
                    de = 1'b0; vs = 1'b1;
                    tick(); tick();
                    vs = 1'b0;
                    repeat (4) tick();
                    return;
                end
                pix = ramp ? {3{8'(8 * r + c)}} : cpix;
                de  = 1'b1;
                tick();
                if (r == 2 && c == 2) begin
                    acc22 = cyc;
                    if (stall) begin
                        en = 1'b0;
                        for (int s = 0; s < 5; s++) begin
                            de  = (s % 2 == 0);
                            pix = 24'hABCDEF;
                            tick();
                        end
                        en = 1'b1;
                    end
                end
            end
        end
        de = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_ramp(input string tag, input int lat);
        chk({tag, "_a_first_mat"}, a_first_mat, 256'h00010208_0A101112);
        chk({tag, "_a_first_col"}, a_first_col, 0);
        chk({tag, "_a_first_row"}, a_first_row, 0);
        chk({tag, "_a_latency"}, a_first_cyc - acc22, lat);
        chk({tag, "_a_ready_cnt"}, a_cnt, 24);
        chk({tag, "_a_done_cnt"}, a_done_cnt, 1);
        chk({tag, "_a_done_col"}, a_done_col, 5);
        chk({tag, "_a_done_row"}, a_done_row, 3);
        chk({tag, "_b_first_mat"}, b_first_mat, b_ramp_mat);
        chk({tag, "_b_ready_cnt"}, b_cnt, 8);
        chk({tag, "_b_done_cnt"}, b_done_cnt, 1);
        chk({tag, "_b_done_pos"}, {b_done_row, b_done_col}, {32'sd1, 32'sd3});
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; de = 1'b0; vs = 1'b0; pix = 24'h000000;
        b_ramp_mat = '0;
        for (int e = 0; e < 25; e++) begin
            b_ramp_mat[199 - 8 * e -: 8] = 8'(8 * (e / 5) + e % 5);
        end
        clear_counts();
        tick(); tick();
        chk("rst_ready", if_a.O_PIXEL_MATRIX_READY, 0);
        chk("rst_matrix", if_a.O_PIXEL_MATRIX, 0);
        chk("rst_col_row", {if_a.O_PIXEL_COLUMN, if_a.O_PIXEL_ROW}, 0);
        chk("rst_done_abort", {if_a.O_FRAME_DONE, if_a.O_FRAME_ABORT, if_b.O_FRAME_ABORT}, 0);
        rst = 1'b1;
        tick();

        send_frame(1'b0, 24'hFF0000, -1, 1'b0);
        chk("gray_red_a", a_first_mat, {8{8'h3F}});
        chk("gray_red_b", b_first_mat, {25{8'h3F}});
        chk("gray_red_cnt", {a_cnt, b_cnt}, {32'sd24, 32'sd8});
        send_frame(1'b0, 24'hFFFFFF, -1, 1'b0);
        chk("gray_white_a", a_first_mat, {8{8'hFF}});
        chk("gray_white_b", b_first_mat, {25{8'hFF}});
        send_frame(1'b0, 24'h008000, -1, 1'b0);
        chk("gray_green_a", a_first_mat, {8{8'h40}});
        chk("gray_green_b", b_first_mat, {25{8'h40}});

        send_frame(1'b1, 24'h0, -1, 1'b0);
        check_ramp("ramp", 2);
        chk("hold_last_mat", if_a.O_PIXEL_MATRIX, 64'h1D1E1F25_272D2E2F);
        chk("hold_last_pos", {if_a.O_PIXEL_ROW, if_a.O_PIXEL_COLUMN}, {3'd3, 3'd5});

        send_frame(1'b1, 24'h0, 20, 1'b0);
        chk("abort_a_cnt", a_abort_cnt, 1);
        chk("abort_b_cnt", b_abort_cnt, 1);
        chk("abort_no_ready", {a_cnt, b_cnt}, 0);
        chk("abort_no_done", {a_done_cnt, b_done_cnt}, 0);
        send_frame(1'b1, 24'h0, -1, 1'b0);
        check_ramp("post_abort", 2);
        chk("post_abort_no_abort", a_abort_cnt + b_abort_cnt, 0);

        send_frame(1'b1, 24'h0, -1, 1'b1);
        check_ramp("stall", 7);

        clear_counts();
        for (int i = 0; i < 31; i++) begin
            pix = {3{8'(i)}};
            de  = 1'b1;
            tick();
        end
        rst = 1'b0; pix = {3{8'd31}};
        tick();
        chk("mrst_ready_done", {if_a.O_PIXEL_MATRIX_READY, if_a.O_FRAME_DONE, if_a.O_FRAME_ABORT}, 0);
        chk("mrst_a_matrix", if_a.O_PIXEL_MATRIX, 0);
        chk("mrst_a_col_row", {if_a.O_PIXEL_COLUMN, if_a.O_PIXEL_ROW}, 0);
        chk("mrst_b_matrix", if_b.O_PIXEL_MATRIX, 0);
        clear_counts();
        rst = 1'b1; de = 1'b0;
        repeat (4) tick();
        chk("mrst_no_stale", {a_cnt, b_cnt}, 0);
        send_frame(1'b1, 24'h0, -1, 1'b0);
        check_ramp("post_rst", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
